// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped 2-bit/target predictor, trained from EX, with mispredict/redirect and perf counters
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int PC_W  = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [PC_W-1:0] fetch_pc_i,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [PC_W-1:0] upd_pred_target_i,
  output logic            mispredict_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic [31:0]     perf_branches_o,
  output logic [31:0]     perf_mispred_o
);
  localparam int DEPTH = 1 << IDX_W;
  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [1:0]       ctr_q [DEPTH];
  logic [PC_W-1:0]  tgt_q [DEPTH];
  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  assign f_idx = fetch_pc_i[IDX_W+1:2];
  assign f_tag = fetch_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && tag_q[f_idx] == f_tag;
  assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  assign pred_taken_o  = f_hit && ctr_q[f_idx][1];
  assign pred_target_o = pred_taken_o ? tgt_q[f_idx] : fetch_pc_i + PC_W'(4);
  assign mispredict_o  = upd_valid_i && ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && upd_target_i != upd_pred_target_i));
  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + PC_W'(4);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= 2'b01;
        tgt_q[i] <= '0;
      end
    end else if (upd_valid_i) begin
      if (u_hit) begin
        ctr_q[u_idx] <= upd_taken_i ? ((&ctr_q[u_idx]) ? 2'b11 : ctr_q[u_idx] + 2'd1)
                                    : ((|ctr_q[u_idx]) ? ctr_q[u_idx] - 2'd1 : 2'b00);
        if (upd_taken_i) tgt_q[u_idx] <= upd_target_i;
      end else if (upd_taken_i) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        ctr_q[u_idx]   <= 2'b10;
        tgt_q[u_idx]   <= upd_target_i;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_branches_o <= '0;
      perf_mispred_o  <= '0;
    end else begin
      perf_branches_o <= perf_branches_o + 32'(upd_valid_i && !(&perf_branches_o));
      perf_mispred_o  <= perf_mispred_o + 32'(mispredict_o && !(&perf_mispred_o));
    end
  end
endmodule
